// File: rtl/i2s_tx_ctl_pkg.sv
// Shared constants, buffer state type and word-select helper for the I2S transmit controller.
package i2s_tx_ctl_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned HALF_FRAME = 32;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned POSN_W     = $clog2(FRAME_BITS);
  localparam int unsigned UCNT_W     = 8;

  localparam logic [POSN_W-1:0] LOAD_POSN = POSN_W'(FRAME_BITS - 1);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Word select for the bit after posn: right channel occupies the upper half-frame.
  function automatic logic ws_for(input logic [POSN_W-1:0] posn);
    logic [POSN_W-1:0] nxt;
    nxt = posn + 1'b1;
    return (32'(nxt) >= HALF_FRAME);
  endfunction

endpackage

// File: rtl/i2s_tx_ctl_if.sv
// Sample-pair handshake between the audio source and the I2S transmit controller.
interface i2s_tx_ctl_if;
  import i2s_tx_ctl_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );

endinterface

// File: rtl/i2s_prescaler.sv
// Bit-period prescaler: one-cycle en strobe at the end of each period and a registered sck.
module i2s_prescaler #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic ck,
  input  logic rst,
  input  logic run,
  output logic en,
  output logic sck
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (run) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // en and sck are registered from the next count so they always match the count they decode.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      en  <= 1'b0;
      sck <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      en  <= (cnt_nxt == LAST);
      sck <= (cnt_nxt >= HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_ctl.sv
// I2S transmit controller: frame timing, word select, one-deep sample buffer and underrun tracking.
module i2s_tx_ctl
  import i2s_tx_ctl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                run,
  i2s_tx_ctl_if.slave         smp,
  output logic                en,
  output logic [POSN_W-1:0]   frame_posn,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right,
  output logic                sck,
  output logic                ws,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_count
);

  buf_state_t          buf_q;
  buf_state_t          buf_d;
  logic                accept;
  logic                xfer;
  logic [SAMPLE_W-1:0] buf_l;
  logic [SAMPLE_W-1:0] buf_r;

  i2s_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .ck (ck),
    .rst(rst),
    .run(run),
    .en (en),
    .sck(sck)
  );

  // run gates the transfer so an en left over from the cycle run fell never loads a frame.
  assign xfer         = run & en & (frame_posn == LOAD_POSN);
  assign smp.in_ready = (buf_q == BUF_EMPTY);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      buf_q <= BUF_EMPTY;
    end else begin
      buf_q <= buf_d;
    end
  end

  always_comb begin
    buf_d  = buf_q;
    accept = 1'b0;
    case (buf_q)
      BUF_EMPTY: begin
        if (smp.in_valid) begin
          accept = 1'b1;
          buf_d  = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (xfer) begin
          buf_d = BUF_EMPTY;
        end
      end
      default: buf_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      buf_l <= '0;
      buf_r <= '0;
    end else if (accept) begin
      buf_l <= smp.in_left;
      buf_r <= smp.in_right;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      frame_posn <= '0;
      ws         <= 1'b0;
    end else if (!run) begin
      frame_posn <= '0;
      ws         <= 1'b0;
    end else if (en) begin
      frame_posn <= frame_posn + 1'b1;
      ws         <= ws_for(frame_posn);
    end
  end

  // An empty buffer at transfer time sends silence; a pair accepted on that same edge waits a frame.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      left           <= '0;
      right          <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (xfer) begin
      if (buf_q == BUF_FULL) begin
        left  <= buf_l;
        right <= buf_r;
      end else begin
        left     <= '0;
        right    <= '0;
        underrun <= 1'b1;
        if (underrun_count != '1) begin
          underrun_count <= underrun_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctl.sv
// Directed bench for i2s_tx_ctl: frame timing loop, per-frame vector table and multi-cycle corner sequences.
module tb_i2s_tx_ctl;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned SAT_DIV = 4;

  logic        ck;
  logic        rst;
  logic        run;
  logic        run2;

  logic        en, sck, ws, underrun;
  logic [5:0]  frame_posn;
  logic [15:0] left, right;
  logic [7:0]  underrun_count;

  logic        en2, sck2, ws2, underrun2;
  logic [5:0]  frame_posn2;
  logic [15:0] left2, right2;
  logic [7:0]  underrun_count2;

  i2s_tx_ctl_if sif ();
  i2s_tx_ctl_if sif2 ();

  i2s_tx_ctl #(.CLK_DIV(CLK_DIV)) dut (
    .ck(ck), .rst(rst), .run(run), .smp(sif),
    .en(en), .frame_posn(frame_posn), .left(left), .right(right),
    .sck(sck), .ws(ws), .underrun(underrun), .underrun_count(underrun_count)
  );

  i2s_tx_ctl #(.CLK_DIV(SAT_DIV)) u_sat (
    .ck(ck), .rst(rst), .run(run2), .smp(sif2),
    .en(en2), .frame_posn(frame_posn2), .left(left2), .right(right2),
    .sck(sck2), .ws(ws2), .underrun(underrun2), .underrun_count(underrun_count2)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic        offer;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vt [6];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    sif.in_valid = 1'b1;
    sif.in_left  = l;
    sif.in_right = r;
    step();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_posn(input logic [5:0] p);
    int unsigned n;
    n = 0;
    while (frame_posn != p && n < 4096) begin
      step();
      n++;
    end
    chk("wait_posn", 32'(frame_posn), 32'(p));
  endtask

  // Stops at the sample point just before a transfer edge.
  task automatic wait_pre_xfer();
    int unsigned n;
    n = 0;
    while (!(en === 1'b1 && frame_posn == 6'd63) && n < 4096) begin
      step();
      n++;
    end
    checks++;
    if (n >= 4096) begin
      errors++;
      $display("FAIL wait_xfer: no transfer within %0d cycles", n);
    end
  endtask

  task automatic check_restart(input string nm);
    for (int unsigned i = 0; i < CLK_DIV; i++) begin
      chk({nm, ".en"}, 32'(en), 32'(i == CLK_DIV - 1));
      chk({nm, ".posn"}, 32'(frame_posn), 32'd0);
      chk({nm, ".ws"}, 32'(ws), 32'd0);
      step();
    end
  endtask

  initial begin
    int unsigned ph;
    int unsigned pos;
    logic [7:0]  exp_ucnt;

    vt[0] = '{1'b1, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 8'd1};
    vt[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd2};
    vt[2] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 8'd2};
    vt[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd3};
    vt[4] = '{1'b1, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 8'd3};
    vt[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 8'd3};

    rst = 1'b1; run = 1'b0; run2 = 1'b0;
    sif.in_valid = 1'b0;  sif.in_left = '0;  sif.in_right = '0;
    sif2.in_valid = 1'b0; sif2.in_left = '0; sif2.in_right = '0;
    repeat (3) @(posedge ck);
    #1;

    chk("rst.en", 32'(en), 32'd0);
    chk("rst.posn", 32'(frame_posn), 32'd0);
    chk("rst.sck", 32'(sck), 32'd0);
    chk("rst.ws", 32'(ws), 32'd0);
    chk("rst.left", 32'(left), 32'd0);
    chk("rst.right", 32'(right), 32'd0);
    chk("rst.underrun", 32'(underrun), 32'd0);
    chk("rst.ucnt", 32'(underrun_count), 32'd0);
    chk("rst.in_ready", 32'(sif.in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Accept works while idle; pair must appear at the first transfer.
    offer(16'h1234, 16'hABCD);
    chk("idle.accept.in_ready", 32'(sif.in_ready), 32'd0);
    chk("idle.posn", 32'(frame_posn), 32'd0);

    run = 1'b1;
    for (int unsigned i = 0; i < 1024; i++) begin
      ph  = i % CLK_DIV;
      pos = (i / CLK_DIV) % 64;
      chk("frm.en", 32'(en), 32'(ph == CLK_DIV - 1));
      chk("frm.sck", 32'(sck), 32'(ph >= CLK_DIV / 2));
      chk("frm.posn", 32'(frame_posn), pos);
      chk("frm.ws", 32'(ws), 32'(pos >= 32));
      chk("frm.left", 32'(left), (i >= 512) ? 32'h1234 : 32'h0);
      chk("frm.right", 32'(right), (i >= 512) ? 32'hABCD : 32'h0);
      chk("frm.in_ready", 32'(sif.in_ready), 32'(i >= 512));
      chk("frm.underrun", 32'(underrun), 32'd0);
      step();
    end
    chk("frm2.left", 32'(left), 32'd0);
    chk("frm2.underrun", 32'(underrun), 32'd1);
    chk("frm2.ucnt", 32'(underrun_count), 32'd1);
    chk("frm2.posn", 32'(frame_posn), 32'd0);

    for (int unsigned k = 0; k < 6; k++) begin
      if (vt[k].offer) offer(vt[k].l, vt[k].r);
      wait_pre_xfer();
      step();
      chk("vec.left", 32'(left), 32'(vt[k].el));
      chk("vec.right", 32'(right), 32'(vt[k].er));
      chk("vec.ucnt", 32'(underrun_count), 32'(vt[k].ecnt));
      chk("vec.underrun", 32'(underrun), 32'd1);
      chk("vec.in_ready", 32'(sif.in_ready), 32'd1);
    end
    exp_ucnt = 8'd3;

    // Offer exactly on the transfer edge with the buffer empty.
    wait_pre_xfer();
    sif.in_valid = 1'b1; sif.in_left = 16'hC0DE; sif.in_right = 16'hBEEF;
    chk("same.in_ready", 32'(sif.in_ready), 32'd1);
    step();
    exp_ucnt = exp_ucnt + 8'd1;
    sif.in_left = 16'h1111; sif.in_right = 16'h2222;
    chk("same.left", 32'(left), 32'd0);
    chk("same.right", 32'(right), 32'd0);
    chk("same.ucnt", 32'(underrun_count), 32'(exp_ucnt));
    chk("same.in_ready", 32'(sif.in_ready), 32'd0);
    wait_pre_xfer();
    step();
    chk("kept.left", 32'(left), 32'hC0DE);
    chk("kept.right", 32'(right), 32'hBEEF);
    chk("kept.ucnt", 32'(underrun_count), 32'(exp_ucnt));
    chk("full.noaccept.in_ready", 32'(sif.in_ready), 32'd1);
    step();
    chk("after.accept.in_ready", 32'(sif.in_ready), 32'd0);
    sif.in_valid = 1'b0;
    wait_pre_xfer();
    step();
    chk("next.left", 32'(left), 32'h1111);
    chk("next.right", 32'(right), 32'h2222);

    // Abort mid-frame by dropping run.
    wait_posn(6'd20);
    run = 1'b0;
    step();
    chk("abort.en", 32'(en), 32'd0);
    chk("abort.posn", 32'(frame_posn), 32'd0);
    chk("abort.sck", 32'(sck), 32'd0);
    chk("abort.ws", 32'(ws), 32'd0);
    repeat (4) step();
    chk("idle.posn", 32'(frame_posn), 32'd0);
    run = 1'b1;
    check_restart("rerun");
    chk("rerun.ucnt", 32'(underrun_count), 32'(exp_ucnt));
    chk("rerun.underrun", 32'(underrun), 32'd1);
    chk("rerun.left", 32'(left), 32'h1111);
    chk("rerun.right", 32'(right), 32'h2222);

    // Reset mid-frame with a pair buffered.
    wait_posn(6'd38);
    offer(16'h7777, 16'h8888);
    chk("pre.rst.in_ready", 32'(sif.in_ready), 32'd0);
    wait_posn(6'd40);
    #3 rst = 1'b1;
    #1;
    chk("arst.en", 32'(en), 32'd0);
    chk("arst.posn", 32'(frame_posn), 32'd0);
    chk("arst.sck", 32'(sck), 32'd0);
    chk("arst.ws", 32'(ws), 32'd0);
    chk("arst.left", 32'(left), 32'd0);
    chk("arst.right", 32'(right), 32'd0);
    chk("arst.underrun", 32'(underrun), 32'd0);
    chk("arst.ucnt", 32'(underrun_count), 32'd0);
    chk("arst.in_ready", 32'(sif.in_ready), 32'd1);
    @(posedge ck);
    @(posedge ck);
    #1;
    rst = 1'b0;
    check_restart("post.rst");
    wait_pre_xfer();
    step();
    chk("discard.left", 32'(left), 32'd0);
    chk("discard.right", 32'(right), 32'd0);
    chk("discard.ucnt", 32'(underrun_count), 32'd1);
    chk("discard.underrun", 32'(underrun), 32'd1);

    // Starved instance: one transfer every 64*SAT_DIV cycles.
    run2 = 1'b1;
    repeat (3 * 64 * SAT_DIV) step();
    chk("sat3.ucnt", 32'(underrun_count2), 32'd3);
    chk("sat3.left", 32'(left2), 32'd0);
    chk("sat3.right", 32'(right2), 32'd0);
    chk("sat3.underrun", 32'(underrun2), 32'd1);
    repeat (255 * 64 * SAT_DIV) step();
    chk("sat.ucnt", 32'(underrun_count2), 32'd255);
    chk("sat.underrun", 32'(underrun2), 32'd1);
    chk("sat.left", 32'(left2), 32'd0);
    chk("sat.in_ready", 32'(sif2.in_ready), 32'd1);
    chk("sat.posn", 32'(frame_posn2), 32'd0);
    chk("sat.en", 32'(en2), 32'd0);
    chk("sat.sck", 32'(sck2), 32'd0);
    chk("sat.ws", 32'(ws2), 32'd0);
    chk("sat.right", 32'(right2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
